// File: rtl/dpsk_tx_scheduler_if.sv
// Requester and modulator-facing signals of the DPSK transmit scheduler.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/data until gnt; the modulator side has none.
interface dpsk_tx_scheduler_if;
    logic       req0;
    logic [7:0] data0;
    logic       gnt0;
    logic       req1;
    logic [7:0] data1;
    logic       gnt1;
    logic       busy;
    logic       src_id;
    logic       tx_en;
    logic       bit_strobe;
    logic       data_bit;
    logic       encoded_bit;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, busy, src_id, tx_en, bit_strobe, data_bit, encoded_bit
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, busy, src_id, tx_en, bit_strobe, data_bit, encoded_bit
    );
endinterface

// File: rtl/dpsk_tx_scheduler.sv
// Round-robin byte scheduler framing preamble+payload+gap with XOR differential encoding.
// Latency: gnt in the IDLE cycle, first bit_strobe the cycle after, one bit per BIT_DIV cycles.
// Backpressure: requests wait while busy and are granted in the first IDLE cycle.
module dpsk_tx_scheduler #(
    parameter int         BIT_DIV  = 150000,
    parameter logic [7:0] PREAMBLE = 8'b10101010,
    parameter int         PRE_LEN  = 8,
    parameter int         GAP_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    dpsk_tx_scheduler_if.slave bus
);
    localparam int TMR_W   = $clog2(BIT_DIV);
    localparam int CNT_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);

    typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       byte_q, byte_nxt;
    logic             ref_q, ref_nxt;
    logic             last_q, last_nxt;
    logic             busy_q, busy_nxt;
    logic             src_q, src_nxt;
    logic             tx_en_q, tx_en_nxt;
    logic             strobe_q, strobe_nxt;
    logic             data_bit_q, data_bit_nxt;
    logic             enc_q, enc_nxt;

    logic grant, win, period_end, send_vld, send_bit, ref_base, enc_val;

    // Grant decodes the registered IDLE state so the byte is captured in the gnt cycle itself.
    assign win        = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    assign grant      = (state == IDLE) && (bus.req0 || bus.req1) && !rst;
    assign period_end = (timer == TMR_LAST);
    assign ref_base   = (state == IDLE) ? 1'b0 : ref_q;
    assign enc_val    = ref_base ^ send_bit;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        byte_nxt     = byte_q;
        ref_nxt      = ref_q;
        last_nxt     = last_q;
        busy_nxt     = busy_q;
        src_nxt      = src_q;
        tx_en_nxt    = tx_en_q;
        strobe_nxt   = 1'b0;
        data_bit_nxt = data_bit_q;
        enc_nxt      = enc_q;
        send_vld     = 1'b0;
        send_bit     = 1'b0;

        if (state != IDLE) begin
            timer_nxt = period_end ? '0 : timer + TMR_W'(1);
        end

        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (grant) begin
                    state_nxt   = PRE;
                    byte_nxt    = win ? bus.data1 : bus.data0;
                    src_nxt     = win;
                    last_nxt    = win;
                    busy_nxt    = 1'b1;
                    tx_en_nxt   = 1'b1;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = {PREAMBLE[6:0], 1'b0};
                    send_vld    = 1'b1;
                    send_bit    = PREAMBLE[7];
                end
            end
            PRE: begin
                if (period_end) begin
                    send_vld = 1'b1;
                    if (bit_cnt == PRE_LAST) begin
                        state_nxt   = PAY;
                        bit_cnt_nxt = '0;
                        send_bit    = byte_q[7];
                        shreg_nxt   = {byte_q[6:0], 1'b0};
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        send_bit    = shreg[7];
                        shreg_nxt   = {shreg[6:0], 1'b0};
                    end
                end
            end
            PAY: begin
                if (period_end) begin
                    if (bit_cnt == PAY_LAST) begin
                        state_nxt    = GAP;
                        bit_cnt_nxt  = '0;
                        tx_en_nxt    = 1'b0;
                        data_bit_nxt = 1'b0;
                        enc_nxt      = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        send_vld    = 1'b1;
                        send_bit    = shreg[7];
                        shreg_nxt   = {shreg[6:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (period_end) begin
                    if (bit_cnt == GAP_LAST) begin
                        state_nxt   = IDLE;
                        bit_cnt_nxt = '0;
                        busy_nxt    = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The reference follows the encoder output so the chain runs unbroken into the payload.
        if (send_vld) begin
            strobe_nxt   = 1'b1;
            data_bit_nxt = send_bit;
            enc_nxt      = enc_val;
            ref_nxt      = enc_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_q     <= '0;
            ref_q      <= 1'b0;
            last_q     <= 1'b1;
            busy_q     <= 1'b0;
            src_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            strobe_q   <= 1'b0;
            data_bit_q <= 1'b0;
            enc_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            byte_q     <= byte_nxt;
            ref_q      <= ref_nxt;
            last_q     <= last_nxt;
            busy_q     <= busy_nxt;
            src_q      <= src_nxt;
            tx_en_q    <= tx_en_nxt;
            strobe_q   <= strobe_nxt;
            data_bit_q <= data_bit_nxt;
            enc_q      <= enc_nxt;
        end
    end

    assign bus.gnt0        = grant && !win;
    assign bus.gnt1        = grant && win;
    assign bus.busy        = busy_q;
    assign bus.src_id      = src_q;
    assign bus.tx_en       = tx_en_q;
    assign bus.bit_strobe  = strobe_q;
    assign bus.data_bit    = data_bit_q;
    assign bus.encoded_bit = enc_q;
endmodule

// File: tb/tb_dpsk_tx_scheduler.sv
// Bench for dpsk_tx_scheduler: two instances (4/8/2 and 2/1/1) against a frame-offset model.
module tb_dpsk_tx_scheduler;
    localparam logic [7:0] PRE  = 8'b10101010;
    localparam int         MAXC = 8192;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpsk_tx_scheduler_if bus_a();
    dpsk_tx_scheduler_if bus_b();

    dpsk_tx_scheduler #(.BIT_DIV(4), .PREAMBLE(PRE), .PRE_LEN(8), .GAP_BITS(2))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dpsk_tx_scheduler #(.BIT_DIV(2), .PREAMBLE(PRE), .PRE_LEN(1), .GAP_BITS(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;
    int last_c = 0;
    bit armed = 1'b0;

    // Trace byte per cycle: {src, enc, data_bit, strobe, tx_en, busy, gnt1, gnt0}
    logic [7:0] tr [2][MAXC];

    bit         m_act  [2];
    bit         m_last [2];
    bit         m_src  [2];
    int         m_start[2];
    logic [7:0] m_byte [2];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, last_c, act, exp);
        end
    endtask

    function automatic logic frame_bit(input int pl, input logic [7:0] b, input int p);
        logic [7:0] pre;
        pre = PRE;
        if (p < pl) return pre[7-p];
        return b[7-(p-pl)];
    endfunction

    function automatic logic frame_enc(input int pl, input logic [7:0] b, input int p);
        logic r;
        r = 1'b0;
        for (int i = 0; i <= p; i++) r = r ^ frame_bit(pl, b, i);
        return r;
    endfunction

    task automatic model_step(input int d, input logic rq0, input logic rq1,
                              input logic [7:0] dt0, input logic [7:0] dt1, input logic [7:0] act);
        int bd, pl, gb, len, k, p;
        logic [7:0] e;
        logic win;
        bd  = (d == 0) ? 4 : 2;
        pl  = (d == 0) ? 8 : 1;
        gb  = (d == 0) ? 2 : 1;
        len = pl + 8;
        e   = '0;
        if (m_act[d] && last_c >= m_start[d] && last_c < m_start[d] + (len + gb) * bd) begin
            k = last_c - m_start[d];
            p = k / bd;
            e[2] = 1'b1;
            e[7] = m_src[d];
            if (p < len) begin
                e[3] = 1'b1;
                e[4] = ((k % bd) == 0);
                e[5] = frame_bit(pl, m_byte[d], p);
                e[6] = frame_enc(pl, m_byte[d], p);
            end
        end
        if (!rst && !e[2] && (rq0 || rq1)) begin
            win  = (rq0 && rq1) ? !m_last[d] : rq1;
            e[0] = !win;
            e[1] = win;
        end
        if (armed) begin
            chk("gnt0",        d, 32'(act[0]), 32'(e[0]));
            chk("gnt1",        d, 32'(act[1]), 32'(e[1]));
            chk("busy",        d, 32'(act[2]), 32'(e[2]));
            chk("tx_en",       d, 32'(act[3]), 32'(e[3]));
            chk("bit_strobe",  d, 32'(act[4]), 32'(e[4]));
            chk("data_bit",    d, 32'(act[5]), 32'(e[5]));
            chk("encoded_bit", d, 32'(act[6]), 32'(e[6]));
            if (e[2]) chk("src_id", d, 32'(act[7]), 32'(e[7]));
        end
        if (rst) begin
            m_act[d]  = 1'b0;
            m_last[d] = 1'b1;
        end else if (e[0] || e[1]) begin
            m_act[d]   = 1'b1;
            m_start[d] = last_c + 1;
            m_src[d]   = e[1];
            m_last[d]  = e[1];
            m_byte[d]  = e[1] ? dt1 : dt0;
        end
    endtask

    task automatic tick();
        logic [7:0] oa, ob;
        @(negedge clk);
        last_c = cyc;
        oa = {bus_a.src_id, bus_a.encoded_bit, bus_a.data_bit, bus_a.bit_strobe,
              bus_a.tx_en, bus_a.busy, bus_a.gnt1, bus_a.gnt0};
        ob = {bus_b.src_id, bus_b.encoded_bit, bus_b.data_bit, bus_b.bit_strobe,
              bus_b.tx_en, bus_b.busy, bus_b.gnt1, bus_b.gnt0};
        if (last_c < MAXC) begin
            tr[0][last_c] = oa;
            tr[1][last_c] = ob;
        end
        model_step(0, bus_a.req0, bus_a.req1, bus_a.data0, bus_a.data1, oa);
        model_step(1, bus_b.req0, bus_b.req1, bus_b.data0, bus_b.data1, ob);
        if (rst) armed = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    function automatic int cnt(input int d, input int b, input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) if (c >= 0 && c < MAXC && tr[d][c][b]) n++;
        return n;
    endfunction

    task automatic wait_gnt(input int d, input int w, input int lim, output int gc);
        gc = -1;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (last_c < MAXC && tr[d][last_c][w]) begin
                gc = last_c;
                break;
            end
        end
        if (gc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_gnt%0d dut%0d got=none within %0d cycles want=grant", w, d, lim);
            gc = last_c;
        end
    endtask

    initial begin
        int g, g1, g2, rc, r;
        int gq_c[$];
        int gq_id[$];
        logic [15:0] s_db, s_enc;
        logic [7:0]  s8;

        m_last[0] = 1'b1; m_last[1] = 1'b1;
        m_act[0]  = 1'b0; m_act[1]  = 1'b0;
        rst = 1'b1;
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.data0 = '0; bus_a.data1 = '0;
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.data0 = '0; bus_b.data1 = '0;
        run(3);
        rst = 1'b0;

        // Single request 0xB6
        bus_a.req0 = 1'b1;
        bus_a.data0 = 8'hB6;
        wait_gnt(0, 0, 10, g);
        bus_a.req0 = 1'b0;
        run(80);
        for (int i = 0; i < 16; i++) begin
            s_db[15-i]  = tr[0][g+1+4*i][5];
            s_enc[15-i] = tr[0][g+1+4*i][6];
        end
        chk("s1_gnt0_count", 0, cnt(0, 0, g, g + 79), 1);
        chk("s1_first_strobe", 0, 32'(tr[0][g+1][4]), 1);
        chk("s1_strobes", 0, cnt(0, 4, g + 1, g + 79), 16);
        chk("s1_data_bits", 0, 32'(s_db), 32'h0000AAB6);
        chk("s1_enc_bits", 0, 32'(s_enc), 32'h0000CCDB);
        chk("s1_tx_en_len", 0, cnt(0, 3, g, g + 79), 64);
        chk("s1_busy_len", 0, cnt(0, 2, g, g + 79), 72);

        // Tie after reset, both requests held
        rst = 1'b1;
        bus_a.req0 = 1'b1; bus_a.data0 = 8'($urandom);
        bus_a.req1 = 1'b1; bus_a.data1 = 8'($urandom);
        run(2);
        rst = 1'b0;
        r = cyc;
        for (int i = 0; i < 400 && gq_c.size() < 4; i++) begin
            tick();
            if (tr[0][last_c][0]) begin gq_c.push_back(last_c); gq_id.push_back(0); end
            if (tr[0][last_c][1]) begin gq_c.push_back(last_c); gq_id.push_back(1); end
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        chk("tie_grants", 0, gq_c.size(), 4);
        if (gq_c.size() == 4) begin
            chk("tie_first_cycle", 0, gq_c[0], r);
            for (int i = 0; i < 4; i++) chk("tie_order", 0, gq_id[i], i % 2);
            for (int i = 1; i < 4; i++) chk("tie_spacing", 0, gq_c[i] - gq_c[i-1], 73);
        end
        run(80);

        // Lone requester 1 twice
        bus_a.req1 = 1'b1; bus_a.data1 = 8'($urandom);
        wait_gnt(0, 1, 10, g1);
        bus_a.req1 = 1'b0;
        run(5);
        bus_a.req1 = 1'b1; bus_a.data1 = 8'($urandom);
        wait_gnt(0, 1, 100, g2);
        bus_a.req1 = 1'b0;
        chk("rep_spacing", 0, g2 - g1, 73);
        run(80);

        // Reset during payload bit 3, req0 held
        bus_a.req0 = 1'b1; bus_a.data0 = 8'($urandom);
        wait_gnt(0, 0, 10, g);
        while (cyc < g + 46) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rc = cyc;
        tick();
        bus_a.req0 = 1'b0;
        chk("rst_busy_low", 0, 32'(tr[0][rc][2]), 0);
        chk("rst_regrant", 0, 32'(tr[0][rc][0]), 1);
        run(40);
        for (int i = 0; i < 8; i++) s8[7-i] = tr[0][rc+1+4*i][6];
        chk("rst_enc_preamble", 0, 32'(s8), 32'h000000CC);
        run(40);

        // Late arrival of req1 during gap
        bus_a.req0 = 1'b1; bus_a.data0 = 8'($urandom);
        wait_gnt(0, 0, 10, g);
        bus_a.req0 = 1'b0;
        while (cyc < g + 66) tick();
        bus_a.req1 = 1'b1; bus_a.data1 = 8'($urandom);
        wait_gnt(0, 1, 20, g1);
        bus_a.req1 = 1'b0;
        chk("late_gnt_cycle", 0, g1 - g, 73);
        chk("late_no_gnt_busy", 0, cnt(0, 0, g + 1, g + 72) + cnt(0, 1, g + 1, g + 72), 0);
        run(80);

        // Small-parameter instance
        bus_b.req0 = 1'b1; bus_b.data0 = 8'($urandom);
        wait_gnt(1, 0, 10, g);
        bus_b.req0 = 1'b0;
        run(25);
        chk("sw_strobes", 1, cnt(1, 4, g + 1, g + 24), 9);
        chk("sw_last_strobe", 1, 32'(tr[1][g+17][4]), 1);
        chk("sw_first_bit", 1, 32'(tr[1][g+1][5]), 1);
        chk("sw_busy_len", 1, cnt(1, 2, g, g + 24), 20);

        // Randomized traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            if (tr[0][last_c][0]) bus_a.req0 = 1'b0;
            else if (!bus_a.req0 && $urandom_range(0, 5) == 0) begin bus_a.req0 = 1'b1; bus_a.data0 = 8'($urandom); end
            if (tr[0][last_c][1]) bus_a.req1 = 1'b0;
            else if (!bus_a.req1 && $urandom_range(0, 5) == 0) begin bus_a.req1 = 1'b1; bus_a.data1 = 8'($urandom); end
            if (tr[1][last_c][0]) bus_b.req0 = 1'b0;
            else if (!bus_b.req0 && $urandom_range(0, 5) == 0) begin bus_b.req0 = 1'b1; bus_b.data0 = 8'($urandom); end
            if (tr[1][last_c][1]) bus_b.req1 = 1'b0;
            else if (!bus_b.req1 && $urandom_range(0, 5) == 0) begin bus_b.req1 = 1'b1; bus_b.data1 = 8'($urandom); end
        end
        rst = 1'b0;
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
        run(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
